// File: rtl/ov5640_reg_seq_if.sv
// ov5640_reg_seq_if: single-byte write request bus between the register
// sequencer (master) and the I2C master controller (slave).
//
// Signals:
//   i2c_start  master->slave  one-cycle transaction trigger
//   i2c_end    slave->master  one-cycle transaction-complete pulse
//   wr_en      master->slave  write enable, held through the transaction
//   rd_en      master->slave  read enable (always 0 from the sequencer)
//   addr_num   master->slave  1 = 16-bit register address
//   byte_addr  master->slave  register address
//   wr_data    master->slave  register data
interface ov5640_reg_seq_if;

   logic        i2c_start;
   logic        i2c_end;
   logic        wr_en;
   logic        rd_en;
   logic        addr_num;
   logic [15:0] byte_addr;
   logic [7:0]  wr_data;

   modport master (
      output i2c_start,
      output wr_en,
      output rd_en,
      output addr_num,
      output byte_addr,
      output wr_data,
      input  i2c_end
   );

   modport slave (
      input  i2c_start,
      input  wr_en,
      input  rd_en,
      input  addr_num,
      input  byte_addr,
      input  wr_data,
      output i2c_end
   );

endinterface

// File: rtl/ov5640_reg_seq.sv
// ov5640_reg_seq: OV5640 register-initialisation sequencer. Walks an
// external {addr16, data8} table and issues one I2C write per entry.
//
// Ports:
//   i_sys_clk      clock (same domain as the I2C controller)
//   i_sys_rst      synchronous active-high reset
//   i_cfg_restart  one-cycle pulse; reruns the table (DONE/ERR only)
//   i_tbl_data     table entry, valid one cycle after o_tbl_idx changes
//   o_tbl_idx      current table index
//   o_cfg_busy     high until the table completes or fails
//   o_cfg_done     level, table completed
//   o_cfg_err      level, an entry exhausted its retries
//   m_i2c          request bus to the I2C controller (master side)
module ov5640_reg_seq #(
   parameter int          REG_NUM      = 250,
   parameter int          IDX_W        = 8,
   parameter int          CNT_WAIT_MAX = 1023,
   parameter logic [15:0] DELAY_ADDR   = 16'hFFFF,
   parameter int          MS_CYCLES    = 1000,
   parameter int          TIMEOUT      = 4095,
   parameter int          MAX_RETRY    = 3
) (
   input  logic             i_sys_clk,
   input  logic             i_sys_rst,
   input  logic             i_cfg_restart,
   input  logic [23:0]      i_tbl_data,
   output logic [IDX_W-1:0] o_tbl_idx,
   output logic             o_cfg_busy,
   output logic             o_cfg_done,
   output logic             o_cfg_err,
   ov5640_reg_seq_if.master m_i2c
);

   localparam int PW_T = $clog2(CNT_WAIT_MAX + 1);
   localparam int PW   = (PW_T < 1) ? 1 : PW_T;
   localparam int TW_T = $clog2(TIMEOUT + 1);
   localparam int TW   = (TW_T < 1) ? 1 : TW_T;
   localparam int RW_T = $clog2(MAX_RETRY + 1);
   localparam int RW   = (RW_T < 1) ? 1 : RW_T;
   // 8-bit ms count times cycles/ms always fits in 8+clog2 bits
   localparam int DW   = 8 + $clog2(MS_CYCLES);

   typedef enum logic [3:0] {
      S_WAIT_PWR,
      S_FETCH,
      S_LATCH,
      S_START,
      S_WAIT_END,
      S_DELAY,
      S_NEXT,
      S_DONE,
      S_ERR
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PW-1:0]    r_pwr_cnt;
   logic [TW-1:0]    r_to_cnt;
   logic [RW-1:0]    r_retry;
   logic [DW-1:0]    r_dly_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [15:0]      r_byte_addr;
   logic [7:0]       r_wr_data;

   logic             w_i2c_start;
   logic             w_wr_en;
   logic             w_busy;
   logic             w_done;
   logic             w_err;
   logic             w_is_dly;
   logic             w_pwr_hit;
   logic             w_to_hit;
   logic             w_retry_max;
   logic             w_dly_hit;
   logic             w_last;
   logic [DW-1:0]    w_dly_tgt;

   assign w_is_dly    = (i_tbl_data[23:8] == DELAY_ADDR);
   assign w_pwr_hit   = (r_pwr_cnt == PW'(CNT_WAIT_MAX - 1));
   assign w_to_hit    = (r_to_cnt == TW'(TIMEOUT - 1));
   assign w_retry_max = (r_retry == RW'(MAX_RETRY));
   assign w_dly_tgt   = DW'(r_wr_data) * DW'(MS_CYCLES);
   assign w_dly_hit   = (r_dly_cnt == w_dly_tgt - 1'b1);
   assign w_last      = (r_idx == IDX_W'(REG_NUM - 1));

   // Next state and Moore outputs
   always_comb begin
      w_state_nxt = r_state;
      w_i2c_start = 1'b0;
      w_wr_en     = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_err       = 1'b0;
      unique case (r_state)
         S_WAIT_PWR: begin
            if (w_pwr_hit)
               w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_state_nxt = S_LATCH;
         end
         S_LATCH: begin
            if (w_is_dly && (i_tbl_data[7:0] != 8'd0))
               w_state_nxt = S_DELAY;
            else if (w_is_dly)
               w_state_nxt = S_NEXT;
            else
               w_state_nxt = S_START;
         end
         S_START: begin
            w_i2c_start = 1'b1;
            w_wr_en     = 1'b1;
            w_state_nxt = S_WAIT_END;
         end
         S_WAIT_END: begin
            w_wr_en = 1'b1;
            // a completion on the timeout cycle still counts
            if (m_i2c.i2c_end)
               w_state_nxt = S_NEXT;
            else if (w_to_hit && w_retry_max)
               w_state_nxt = S_ERR;
            else if (w_to_hit)
               w_state_nxt = S_START;
         end
         S_DELAY: begin
            if (w_dly_hit)
               w_state_nxt = S_NEXT;
         end
         S_NEXT: begin
            if (w_last)
               w_state_nxt = S_DONE;
            else
               w_state_nxt = S_FETCH;
         end
         S_DONE: begin
            w_busy = 1'b0;
            w_done = 1'b1;
            if (i_cfg_restart)
               w_state_nxt = S_FETCH;
         end
         S_ERR: begin
            w_busy = 1'b0;
            w_err  = 1'b1;
            if (i_cfg_restart)
               w_state_nxt = S_FETCH;
         end
         default: begin
            w_state_nxt = S_WAIT_PWR;
         end
      endcase
   end

   // State register and datapath
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_state     <= S_WAIT_PWR;
         r_pwr_cnt   <= '0;
         r_to_cnt    <= '0;
         r_retry     <= '0;
         r_dly_cnt   <= '0;
         r_idx       <= '0;
         r_byte_addr <= '0;
         r_wr_data   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_WAIT_PWR)
            r_pwr_cnt <= r_pwr_cnt + 1'b1;
         else
            r_pwr_cnt <= '0;
         unique case (r_state)
            S_LATCH: begin
               r_byte_addr <= i_tbl_data[23:8];
               r_wr_data   <= i_tbl_data[7:0];
               r_retry     <= '0;
               r_dly_cnt   <= '0;
            end
            S_START: begin
               r_to_cnt <= '0;
            end
            S_WAIT_END: begin
               r_to_cnt <= r_to_cnt + 1'b1;
               if (!m_i2c.i2c_end && w_to_hit && !w_retry_max)
                  r_retry <= r_retry + 1'b1;
            end
            S_DELAY: begin
               r_dly_cnt <= r_dly_cnt + 1'b1;
            end
            S_NEXT: begin
               if (!w_last)
                  r_idx <= r_idx + 1'b1;
            end
            S_DONE, S_ERR: begin
               if (i_cfg_restart)
                  r_idx <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign o_tbl_idx       = r_idx;
   assign o_cfg_busy      = w_busy;
   assign o_cfg_done      = w_done;
   assign o_cfg_err       = w_err;

   assign m_i2c.i2c_start = w_i2c_start;
   assign m_i2c.wr_en     = w_wr_en;
   assign m_i2c.rd_en     = 1'b0;
   assign m_i2c.addr_num  = 1'b1;
   assign m_i2c.byte_addr = r_byte_addr;
   assign m_i2c.wr_data   = r_wr_data;

endmodule

// File: tb/tb_ov5640_reg_seq.sv
// tb_ov5640_reg_seq: scoreboard bench for the OV5640 register sequencer.
// Six-entry table with a 2 ms delay entry and a zero delay entry.
module tb_ov5640_reg_seq;

   localparam int IDX_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             restart = 1'b0;
   logic [23:0]      tbl_data;
   logic [IDX_W-1:0] tbl_idx;
   logic             busy;
   logic             done;
   logic             err;

   ov5640_reg_seq_if bus ();

   ov5640_reg_seq #(
      .REG_NUM      (6),
      .IDX_W        (IDX_W),
      .CNT_WAIT_MAX (10),
      .DELAY_ADDR   (16'hFFFF),
      .MS_CYCLES    (10),
      .TIMEOUT      (20),
      .MAX_RETRY    (3)
   ) dut (
      .i_sys_clk     (clk),
      .i_sys_rst     (rst),
      .i_cfg_restart (restart),
      .i_tbl_data    (tbl_data),
      .o_tbl_idx     (tbl_idx),
      .o_cfg_busy    (busy),
      .o_cfg_done    (done),
      .o_cfg_err     (err),
      .m_i2c         (bus)
   );

   always #5 clk = ~clk;

   logic [23:0] rom [0:5];
   initial begin
      rom[0] = 24'h3008_82;
      rom[1] = 24'h3103_03;
      rom[2] = 24'hFFFF_02;
      rom[3] = 24'h4300_61;
      rom[4] = 24'hFFFF_00;
      rom[5] = 24'h3820_41;
   end

   // registered table read: one cycle latency
   always @(posedge clk) tbl_data <= rom[tbl_idx];

   int cyc = 0;
   int base = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ncmp = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc - base);
      end
   endtask

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      int          t;
   } exp_t;

   exp_t q[$];

   task automatic push(input logic [15:0] a, input logic [7:0] d,
                       input int t);
      exp_t e;
      e.a = a;
      e.d = d;
      e.t = t;
      q.push_back(e);
   endtask

   // monitor: every i2c_start pulse must match the next expected write
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.i2c_start === 1'b1) begin
            if (q.size() == 0) begin
               ncmp++;
               nerr++;
               $display("FAIL unexpected_start: got addr %h at cycle %0d expected none",
                        bus.byte_addr, cyc - base);
            end else begin
               e = q.pop_front();
               chk("start_cycle", 32'(cyc - base), 32'(e.t));
               chk("start_addr", 32'(bus.byte_addr), 32'(e.a));
               chk("start_data", 32'(bus.wr_data), 32'(e.d));
               chk("start_wr_en", 32'(bus.wr_en), 32'd1);
            end
         end
      end
   end

   // I2C controller model
   int lat = 5;
   int skip = 0;
   bit never_3103 = 1'b0;
   int ecnt = 0;

   initial begin
      bus.i2c_end = 1'b0;
      forever begin
         @(negedge clk);
         bus.i2c_end = 1'b0;
         if (ecnt > 0) begin
            ecnt--;
            if (ecnt == 0)
               bus.i2c_end = 1'b1;
         end
         if (bus.i2c_start === 1'b1) begin
            if (skip > 0)
               skip--;
            else if (!(never_3103 && bus.byte_addr == 16'h3103))
               ecnt = lat;
         end
      end
   end

   task automatic wait_to(input int n);
      while (cyc - base < n) @(negedge clk);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_idx"}, 32'(tbl_idx), 32'd0);
      chk({tag, "_start"}, 32'(bus.i2c_start), 32'd0);
      chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
      chk({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
      chk({tag, "_addr_num"}, 32'(bus.addr_num), 32'd1);
      chk({tag, "_byte_addr"}, 32'(bus.byte_addr), 32'd0);
      chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_rst("rst0");
      rst = 1'b0;
      base = cyc;

      // run 1: normal walk, restart ignored in WAIT_END
      push(16'h3008, 8'h82, 12);
      push(16'h3103, 8'h03, 21);
      push(16'h4300, 8'h61, 53);
      push(16'h3820, 8'h41, 65);
      wait_to(5);
      chk("pwr_busy", 32'(busy), 32'd1);
      wait_to(14);
      pulse_restart();
      chk("wait_end_wr_en", 32'(bus.wr_en), 32'd1);
      chk("wait_end_idx", 32'(tbl_idx), 32'd0);
      wait_to(18);
      chk("next_wr_en", 32'(bus.wr_en), 32'd0);
      wait_to(40);
      chk("delay_wr_en", 32'(bus.wr_en), 32'd0);
      chk("delay_idx", 32'(tbl_idx), 32'd2);
      wait_to(71);
      chk("pre_done_busy", 32'(busy), 32'd1);
      chk("pre_done_done", 32'(done), 32'd0);
      wait_to(72);
      chk("done1_done", 32'(done), 32'd1);
      chk("done1_busy", 32'(busy), 32'd0);
      chk("done1_err", 32'(err), 32'd0);
      chk("done1_idx", 32'(tbl_idx), 32'd5);

      // run 2: restart from DONE, first attempt withheld, end on timeout tie
      wait_to(74);
      skip = 1;
      push(16'h3008, 8'h82, 78);
      push(16'h3008, 8'h82, 99);
      push(16'h3103, 8'h03, 108);
      push(16'h4300, 8'h61, 140);
      push(16'h3820, 8'h41, 167);
      wait_to(75);
      pulse_restart();
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_idx", 32'(tbl_idx), 32'd0);
      wait_to(120);
      lat = 20;
      wait_to(188);
      chk("pre_done2", 32'(done), 32'd0);
      wait_to(189);
      chk("done2_done", 32'(done), 32'd1);
      chk("done2_err", 32'(err), 32'd0);
      chk("done2_idx", 32'(tbl_idx), 32'd5);

      // run 3: entry 1 never acknowledged -> ERR at index 1
      wait_to(190);
      lat = 5;
      never_3103 = 1'b1;
      push(16'h3008, 8'h82, 195);
      push(16'h3103, 8'h03, 204);
      push(16'h3103, 8'h03, 225);
      push(16'h3103, 8'h03, 246);
      push(16'h3103, 8'h03, 267);
      wait_to(192);
      pulse_restart();
      wait_to(287);
      chk("pre_err_err", 32'(err), 32'd0);
      chk("pre_err_busy", 32'(busy), 32'd1);
      wait_to(288);
      chk("err_err", 32'(err), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_done", 32'(done), 32'd0);
      chk("err_idx", 32'(tbl_idx), 32'd1);

      // run 4: restart from ERR, reset during WAIT_END
      wait_to(289);
      never_3103 = 1'b0;
      push(16'h3008, 8'h82, 293);
      wait_to(290);
      pulse_restart();
      wait_to(292);
      chk("restart_err_clr", 32'(err), 32'd0);
      wait_to(295);
      chk("pre_rst_wr_en", 32'(bus.wr_en), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      base = cyc;
      chk_rst("rst1");
      push(16'h3008, 8'h82, 12);
      push(16'h3103, 8'h03, 21);
      push(16'h4300, 8'h61, 53);
      push(16'h3820, 8'h41, 65);
      wait_to(72);
      chk("done4_done", 32'(done), 32'd1);
      chk("done4_idx", 32'(tbl_idx), 32'd5);
      wait_to(80);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
